// File: rtl/fir2p_stream_ctrl_if.sv
// Valid/ready stream bundle used for the sample input and the filtered output.
interface fir2p_stream_ctrl_if #(
  parameter int W = 16
);
  logic         valid;
  logic [W-1:0] data;
  logic         ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fir2p_stream_ctrl.sv
// Pair packer / issue / capture / serialiser around the two-parallel FIR datapath.
// Define FIR2P_WARMUP_SUPPRESS_EN to drop outputs issued before the delay line is full.
module fir2p_stream_ctrl #(
  parameter int DW   = 16,
  parameter int OW   = 64,
  parameter int TAPS = 102
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  fir2p_stream_ctrl_if.slave     s,
  fir2p_stream_ctrl_if.master    m,
  output logic                   fir_ce,
  output logic                   fir_rst,
  output logic [DW-1:0]          fir_din1,
  output logic [DW-1:0]          fir_din2,
  input  logic [OW-1:0]          fir_dout1,
  input  logic [OW-1:0]          fir_dout2,
  output logic [31:0]            pair_count
);

  localparam int WARM_MAX = TAPS / 2 - 1;
  localparam int WARM_W   = $clog2(WARM_MAX + 1);
`ifdef FIR2P_WARMUP_SUPPRESS_EN
  localparam bit SUPPRESS = 1'b1;
`else
  localparam bit SUPPRESS = 1'b0;
`endif

  typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} pk_state_e;

  pk_state_e            state_q;
  logic [1:0][DW-1:0]   pair_q;
  logic                 cap_pend_q;
  logic                 cap_keep_q;
  logic [1:0][OW-1:0]   out_q;
  logic [1:0]           out_cnt_q, out_cnt_d;
  logic [31:0]          pair_cnt_q, pair_cnt_d;
  logic [WARM_W-1:0]    warm_q, warm_d;
  logic                 clr, accept, pop, issue;

  assign clr    = rst | flush;
  assign accept = s.valid & s.ready;
  assign pop    = m.valid & m.ready;
  // Issue only once the output slot reads empty as registered; a last pop never overlaps an issue.
  assign issue  = (state_q == FULL) & ~cap_pend_q & (out_cnt_q == 2'd0) & ~clr;

  assign s.ready    = (state_q != FULL) & ~flush;
  assign m.valid    = (out_cnt_q != 2'd0);
  assign m.data     = (out_cnt_q == 2'd2) ? out_q[0] :
                      (out_cnt_q == 2'd1) ? out_q[1] : '0;
  assign fir_ce     = issue;
  assign fir_rst    = clr;
  assign fir_din1   = pair_q[0];
  assign fir_din2   = pair_q[1];
  assign pair_count = pair_cnt_q;

  always_comb begin
    pair_cnt_d = pair_cnt_q;
    warm_d     = warm_q;
    out_cnt_d  = out_cnt_q;
    if (issue) begin
      if (pair_cnt_q != '1)
        pair_cnt_d = pair_cnt_q + 32'd1;
      if (warm_q != WARM_W'(WARM_MAX))
        warm_d = warm_q + 1'b1;
    end
    if (cap_pend_q && cap_keep_q)
      out_cnt_d = 2'd2;
    else if (pop)
      out_cnt_d = out_cnt_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= EMPTY;
      pair_q     <= '0;
      cap_pend_q <= 1'b0;
      cap_keep_q <= 1'b0;
      out_q      <= '0;
      out_cnt_q  <= 2'd0;
      pair_cnt_q <= 32'd0;
      warm_q     <= '0;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          pair_q[0] <= s.data;
          state_q   <= HALF;
        end
        HALF: if (accept) begin
          pair_q[1] <= s.data;
          state_q   <= FULL;
        end
        FULL: if (issue) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
      cap_pend_q <= issue;
      // Pair index WARM_MAX is the first one computed from a full delay line.
      cap_keep_q <= ~SUPPRESS | (warm_q == WARM_W'(WARM_MAX));
      if (cap_pend_q && cap_keep_q) begin
        out_q[0] <= fir_dout1;
        out_q[1] <= fir_dout2;
      end
      out_cnt_q  <= out_cnt_d;
      pair_cnt_q <= pair_cnt_d;
      warm_q     <= warm_d;
    end
  end

endmodule
